pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_pkg.sv | 15 +
 rtl/pattern_shreg.sv | 39 +++
 rtl/pattern_tx.sv | 144 ++++++++++++++
 tb/tb_pattern_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and defaults for the pattern transmitter.
// Holds the FSM state encoding and default WIDTH/GAP values.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP_WAIT,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 2;

endpackage

// File: rtl/pattern_shreg.sv
// Load/shift register and bit counter for one frame.
// Ports: clk, rst, clr, load, shift, data, count -> bit_out, last_bit.
module pattern_shreg #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    count,
    output logic             bit_out,
    output logic             last_bit
);

    logic [WIDTH-1:0] sr;
    logic [LW-1:0]    cnt;

    // data arrives left-aligned, so the frame's first bit sits in the MSB
    // and shifting in zeros leaves the register clear after the frame.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data;
            cnt <= count;
        end else if (shift) begin
            sr  <= sr << 1;
            cnt <= cnt - LW'(1);
        end
    end

    assign bit_out  = sr[WIDTH-1];
    assign last_bit = (cnt == LW'(1));

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured frame reps+1 times with gaps.
// Ports: clk, rst, start, abort, pat, len, reps -> out, out_valid, busy, done.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WIDTH-1:0]       pat,
    input  logic [$clog2(WIDTH):0] len,
    input  logic [3:0]             reps,
    output logic                   out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int LW = $clog2(WIDTH) + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] cap_pat;
    logic [LW-1:0]    cap_len;
    logic [4:0]       frames, frames_n;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic             cap_en, load, shift, clr;
    logic             valid_n, busy_n, done_n;
    logic             last_bit, len_ok;
    logic [WIDTH-1:0] aligned, load_data;
    logic [LW-1:0]    load_len;

    assign len_ok    = (len != '0) && (len <= LW'(WIDTH));
    assign aligned   = pat << (LW'(WIDTH) - len);
    assign load_data = cap_en ? aligned : cap_pat;
    assign load_len  = cap_en ? len : cap_len;

    pattern_shreg #(
        .WIDTH (WIDTH),
        .LW    (LW)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .shift    (shift),
        .data     (load_data),
        .count    (load_len),
        .bit_out  (out),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap_pat   <= '0;
            cap_len   <= '0;
            frames    <= '0;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            frames    <= frames_n;
            gap_cnt   <= gap_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
            if (cap_en) begin
                cap_pat <= aligned;
                cap_len <= len;
            end
        end
    end

    // frames counts the frames still to start after the current one.
    always_comb begin
        state_n  = state;
        frames_n = frames;
        gap_n    = gap_cnt;
        cap_en   = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        clr      = 1'b0;
        valid_n  = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!abort && start && len_ok) begin
                    state_n  = SHIFT;
                    cap_en   = 1'b1;
                    load     = 1'b1;
                    frames_n = {1'b0, reps};
                    valid_n  = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                    clr     = 1'b1;
                end else if (!last_bit) begin
                    shift   = 1'b1;
                    valid_n = 1'b1;
                end else if (frames != '0) begin
                    if (GAP > 0) begin
                        state_n = GAP_WAIT;
                        clr     = 1'b1;
                        gap_n   = GW'(GAP);
                    end else begin
                        load     = 1'b1;
                        frames_n = frames - 5'd1;
                        valid_n  = 1'b1;
                    end
                end else begin
                    state_n = DONE;
                    clr     = 1'b1;
                    done_n  = 1'b1;
                end
            end
            GAP_WAIT: begin
                if (abort) begin
                    state_n = IDLE;
                    clr     = 1'b1;
                end else if (gap_cnt <= GW'(1)) begin
                    state_n  = SHIFT;
                    load     = 1'b1;
                    frames_n = frames - 5'd1;
                    valid_n  = 1'b1;
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized scoreboard bench for pattern_tx with GAP=2 and GAP=0 instances.
// Expected per-cycle {out,out_valid,busy,done} records are queued at start.
module tb_pattern_tx;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pat   = '0;
    logic [3:0] len   = '0;
    logic [3:0] reps  = '0;

    logic out2, v2, b2, d2;
    logic out0, v0, b0, d0;

    pattern_tx #(.WIDTH(8), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat(pat), .len(len), .reps(reps),
        .out(out2), .out_valid(v2), .busy(b2), .done(d2)
    );

    pattern_tx #(.WIDTH(8), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pat(pat), .len(len), .reps(reps),
        .out(out0), .out_valid(v0), .busy(b0), .done(d0)
    );

    always #5 clk = ~clk;

    logic [3:0] q2[$];
    logic [3:0] q0[$];
    int         tests  = 0;
    int         fails  = 0;
    bit         mon_en = 1'b0;
    logic [3:0] e2, e0;

    // Monitor: one expected record per cycle; an empty queue means idle.
    always @(negedge clk) begin
        if (mon_en) begin
            e2 = (q2.size() != 0) ? q2.pop_front() : 4'b0000;
            e0 = (q0.size() != 0) ? q0.pop_front() : 4'b0000;
            tests++;
            if ({out2, v2, b2, d2} !== e2) begin
                fails++;
                $display("FAIL gap2 t=%0t out/valid/busy/done got %b want %b",
                         $time, {out2, v2, b2, d2}, e2);
            end
            tests++;
            if ({out0, v0, b0, d0} !== e0) begin
                fails++;
                $display("FAIL gap0 t=%0t out/valid/busy/done got %b want %b",
                         $time, {out0, v0, b0, d0}, e0);
            end
        end
    end

    // Reference: frame = pat[len-1..0], repeated reps+1 times,
    // GAP idle-but-busy cycles between frames, then one done cycle.
    task automatic push_exp(input logic [7:0] p, input int l, input int r);
        int         gap;
        logic [3:0] e;
        for (int g = 0; g < 2; g++) begin
            gap = (g == 0) ? 2 : 0;
            for (int f = 0; f <= r; f++) begin
                for (int i = l - 1; i >= 0; i--) begin
                    e = {p[i], 3'b110};
                    if (g == 0) q2.push_back(e);
                    else q0.push_back(e);
                end
                if (f < r) begin
                    for (int k = 0; k < gap; k++) begin
                        if (g == 0) q2.push_back(4'b0010);
                        else q0.push_back(4'b0010);
                    end
                end
            end
            if (g == 0) q2.push_back(4'b0011);
            else q0.push_back(4'b0011);
        end
    endtask

    // Called just after a rising edge with both DUTs idle.
    task automatic send(input logic [7:0] p, input int l, input int r);
        pat   = p;
        len   = 4'(l);
        reps  = 4'(r);
        start = 1'b1;
        @(posedge clk);
        if (l >= 1 && l <= 8 && !abort) push_exp(p, l, r);
        #1;
        start = 1'b0;
        pat   = 8'($urandom);
        len   = 4'($urandom);
        reps  = 4'($urandom);
    endtask

    task automatic busy_start();
        start = 1'b1;
        pat   = 8'($urandom);
        len   = 4'($urandom_range(1, 8));
        reps  = 4'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q2.size() != 0 || q0.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL timeout waiting for idle, q2=%0d q0=%0d left",
                     q2.size(), q0.size());
            q2.delete();
            q0.delete();
        end
    endtask

    task automatic do_abort(input int delay);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        q2.delete();
        q0.delete();
        #1;
        abort = 1'b0;
    endtask

    initial begin
        int p, l, r;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(8'b0000_0101, 3, 0);
        wait_idle();
        send(8'b0000_0101, 3, 2);
        wait_idle();

        send(8'b0000_0101, 3, 2);
        busy_start();
        busy_start();
        wait_idle();

        send(8'hFF, 0, 3);
        send(8'hFF, 9, 0);
        send(8'hFF, 15, 1);
        wait_idle();

        abort = 1'b1;
        send(8'hFF, 4, 1);
        abort = 1'b0;
        wait_idle();

        send(8'hA5, 8, 1);
        do_abort(1);
        send(8'h3C, 6, 0);
        wait_idle();

        send(8'b0000_0101, 3, 2);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        q2.delete();
        q0.delete();
        #1;
        rst = 1'b0;
        send(8'hA5, 8, 0);
        wait_idle();

        send(8'h02, 2, 15);
        wait_idle();
        send(8'h01, 1, 3);
        wait_idle();
        send(8'hFE, 1, 1);
        wait_idle();

        for (int t = 0; t < 40; t++) begin
            p = int'($urandom_range(0, 255));
            l = int'($urandom_range(0, 10));
            r = int'($urandom_range(0, 15));
            send(8'(p), l, r);
            if (l >= 1 && l <= 8) begin
                if ($urandom_range(0, 1) == 1) busy_start();
                if ($urandom_range(0, 7) == 0)
                    do_abort(int'($urandom_range(0, 6)));
            end
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
